// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state enum and datapath select encodings
// for the multicycle MIPS control unit.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12
   } state_e;

   typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10} pc_src_e;
   typedef enum logic [1:0] {A_PC = 2'b00, A_REGA = 2'b01, A_ZERO = 2'b10} alu_a_e;
   typedef enum logic [2:0] {
      B_REGB = 3'b000, B_FOUR = 3'b001, B_SEXT = 3'b010, B_SEXT_SH2 = 3'b011, B_LUI = 3'b100
   } alu_b_e;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_SLT = 2'b11} alu_op_e;
   typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} reg_dst_e;
   typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} mem_to_reg_e;

   typedef struct packed {
      logic        mem_req;
      logic        iord;
      logic        mem_write;
      logic        ir_write;
      logic        pc_write;
      logic        branch;
      logic        branch_ne;
      pc_src_e     pc_src;
      alu_a_e      alu_src_a;
      alu_b_e      alu_src_b;
      alu_op_e     alu_op;
      logic        apply_shift;
      logic        reg_write;
      reg_dst_e    reg_dst;
      mem_to_reg_e mem_to_reg;
      logic        illegal_op;
   } ctrl_t;

   // The extended ops decode only when the build enables them.
   function automatic logic op_legal(input logic [5:0] op, input logic ext_en);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
         OP_BNE, OP_JAL, OP_LUI, OP_SLTI:               return ext_en;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mcp_out_dec.sv
// Moore output decode: maps the current state (plus IR fields and memory
// ready for the few qualified strobes) onto the datapath control word.
module mcp_out_dec
   import mips_pkg::*;
#(
   parameter bit EXT_OPS_EN = 1'b1
) (
   input  state_e     state,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      // NOTE: a full default ahead of the case keeps this purely combinational for every state/op.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_b = B_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = B_SEXT_SH2;
            ctrl.illegal_op = ~op_legal(op, EXT_OPS_EN);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = A_REGA;
            ctrl.alu_src_b = B_SEXT;
         end
         S_MEMRD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.mem_write = mem_ready;
         end
         S_EXEC: begin
            ctrl.alu_src_a   = A_REGA;
            ctrl.alu_op      = ALU_FUNCT;
            ctrl.apply_shift = (funct == FN_SLL) || (funct == FN_SRL);
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = RD_RD;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = A_REGA;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_ALUOUT;
            ctrl.branch    = (op == OP_BEQ);
            ctrl.branch_ne = (op == OP_BNE);
         end
         S_IMMEX: begin
            case (op)
               OP_SLTI: begin
                  ctrl.alu_src_a = A_REGA;
                  ctrl.alu_src_b = B_SEXT;
                  ctrl.alu_op    = ALU_SLT;
               end
               OP_LUI: begin
                  ctrl.alu_src_a = A_ZERO;
                  ctrl.alu_src_b = B_LUI;
               end
               default: begin
                  ctrl.alu_src_a = A_REGA;
                  ctrl.alu_src_b = B_SEXT;
               end
            endcase
         end
         S_IMMWB: ctrl.reg_write = 1'b1;
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_JUMP;
         end
         S_JAL: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_src     = PC_JUMP;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RD_RA;
            ctrl.mem_to_reg = M2R_PC;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs
// come from mcp_out_dec with write strobes forced low while in reset.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter bit EXT_OPS_EN  = 1'b1,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [5:0] op_i6,
   input  logic [5:0] funct_i6,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       iord_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       branch_o,
   output logic       branch_ne_o,
   output logic [1:0] pc_src_o2,
   output logic [1:0] alu_src_a_o2,
   output logic [2:0] alu_src_b_o3,
   output logic [1:0] alu_op_o2,
   output logic       apply_shift_o,
   output logic       reg_write_o,
   output logic [1:0] reg_dst_o2,
   output logic [1:0] mem_to_reg_o2,
   output logic       illegal_op_o,
   output logic [3:0] state_o4
);

   state_e state, state_nxt;
   ctrl_t  ctrl;
   logic   ready;
   logic   unused_zero;

   // Branch resolution happens in the datapath from branch/branch_ne and the zero flag.
   assign unused_zero = zero_i;
   assign ready       = MEM_WAIT_EN ? mem_ready_i : 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking so every reader of state sees the pre-edge value.
      if (!rst_ni) state <= S_FETCH;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (ready) state_nxt = S_DECODE;
         S_DECODE: begin
            state_nxt = S_FETCH;
            if (op_legal(op_i6, EXT_OPS_EN)) begin
               case (op_i6)
                  OP_RTYPE:                 state_nxt = S_EXEC;
                  OP_LW, OP_SW:             state_nxt = S_MEMADR;
                  OP_BEQ, OP_BNE:           state_nxt = S_BRANCH;
                  OP_ADDI, OP_SLTI, OP_LUI: state_nxt = S_IMMEX;
                  OP_J:                     state_nxt = S_JUMP;
                  OP_JAL:                   state_nxt = S_JAL;
                  default:                  state_nxt = S_FETCH;
               endcase
            end
         end
         S_MEMADR: state_nxt = (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (ready) state_nxt = S_MEMWB;
         S_MEMWR:  if (ready) state_nxt = S_FETCH;
         S_EXEC:   state_nxt = S_ALUWB;
         S_IMMEX:  state_nxt = S_IMMWB;
         default:  state_nxt = S_FETCH;
      endcase
   end

   mcp_out_dec #(.EXT_OPS_EN(EXT_OPS_EN)) u_out_dec (
      .state     (state),
      .op        (op_i6),
      .funct     (funct_i6),
      .mem_ready (ready),
      .ctrl      (ctrl)
   );

   // FETCH is combinationally ready-qualified, so strobes need explicit reset gating.
   assign ir_write_o    = ctrl.ir_write   & rst_ni;
   assign pc_write_o    = ctrl.pc_write   & rst_ni;
   assign mem_write_o   = ctrl.mem_write  & rst_ni;
   assign reg_write_o   = ctrl.reg_write  & rst_ni;
   assign illegal_op_o  = ctrl.illegal_op & rst_ni;
   assign mem_req_o     = ctrl.mem_req;
   assign iord_o        = ctrl.iord;
   assign branch_o      = ctrl.branch;
   assign branch_ne_o   = ctrl.branch_ne;
   assign pc_src_o2     = ctrl.pc_src;
   assign alu_src_a_o2  = ctrl.alu_src_a;
   assign alu_src_b_o3  = ctrl.alu_src_b;
   assign alu_op_o2     = ctrl.alu_op;
   assign apply_shift_o = ctrl.apply_shift;
   assign reg_dst_o2    = ctrl.reg_dst;
   assign mem_to_reg_o2 = ctrl.mem_to_reg;
   assign state_o4      = state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter EXT_OPS_EN, default 1: when 1, BNE/JAL/LUI/SLTI are legal; when 0, they are illegal ops.
REQ-002 SHALL have parameter MEM_WAIT_EN, default 1: when 1, memory states honour mem_ready_i; when 0, mem_ready_i is treated as constant 1.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk_i  in  1  clock, rising edge; rst_ni  in  1  async active-low reset.
REQ-004 Control inputs: op_i6  in  6  IR opcode; funct_i6  in  6  IR funct; zero_i  in  1  ALU zero flag; mem_ready_i  in  1  memory access done this cycle.
REQ-005 Memory outputs: mem_req_o  out  1  memory access active; iord_o  out  1  address select (0 = PC, 1 = ALUOut); mem_write_o  out  1  store strobe.
REQ-006 Fetch outputs: ir_write_o  out  1  IR load; pc_write_o  out  1  unconditional PC load; branch_o  out  1  BEQ qualifier; branch_ne_o  out  1  BNE qualifier.
REQ-007 Datapath selects: pc_src_o2  out  2  (00 ALU result, 01 ALUOut, 10 jump target); alu_src_a_o2  out  2  (00 PC, 01 regA, 10 zero).
REQ-008 ALU source B: alu_src_b_o3  out  3  (000 regB, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 imm<<16).
REQ-009 ALU control: alu_op_o2  out  2  (00 add, 01 sub, 10 use funct, 11 slt); apply_shift_o  out  1  shift op.
REQ-010 Register-file outputs: reg_write_o  out  1  RF write; reg_dst_o2  out  2  (00 rt, 01 rd, 10 $31); mem_to_reg_o2  out  2  (00 ALUOut, 01 MDR, 10 PC).
REQ-011 Status outputs: illegal_op_o  out  1  one-cycle pulse on undecodable op; state_o4  out  4  current state, debug.

Function
REQ-012 Moore FSM; outputs SHALL decode from state only, except write strobes gated by mem_ready_i as stated below.
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, JAL.
REQ-014 FETCH: mem_req=1, iord=0, src_a=00, src_b=001, alu_op=00, pc_src=00; ir_write and pc_write = mem_ready; stay until mem_ready, then go to DECODE.
REQ-015 DECODE: src_a=00, src_b=011, alu_op=00 (branch target into ALUOut). Next state by op:
 - RTYPE -> EXEC
 - LW/SW -> MEMADR
 - BEQ/BNE -> BRANCH
 - ADDI/SLTI/LUI -> IMMEX
 - J -> JUMP
 - JAL -> JAL
 - other -> FETCH with illegal_op_o=1 for that cycle.
REQ-016 MEMADR: src_a=01, src_b=010, alu_op=00; next MEMRD for LW, MEMWR for SW.
REQ-017 MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB. MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; next FETCH.
REQ-018 MEMWR: mem_req=1, iord=1, mem_write=mem_ready; wait for mem_ready, then FETCH.
REQ-019 EXEC: src_a=01, src_b=000, alu_op=10; apply_shift=1 iff funct is SLL (000000) or SRL (000010); next ALUWB.
REQ-020 ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00; next FETCH.
REQ-021 BRANCH: src_a=01, src_b=000, alu_op=01, pc_src=01; branch=1 for BEQ, branch_ne=1 for BNE; next FETCH.
REQ-022 IMMEX operand selects:
 - ADDI: src_a=01, src_b=010, alu_op=00
 - SLTI: src_a=01, src_b=010, alu_op=11
 - LUI: src_a=10, src_b=100, alu_op=00
 Next state IMMWB. IMMWB: reg_write=1, reg_dst=00, mem_to_reg=00; next FETCH.
REQ-023 JUMP: pc_write=1, pc_src=10; next FETCH. JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; next FETCH.
REQ-024 Unlisted outputs SHALL be 0 in every state; no X values SHALL appear on any output.
REQ-025 Latency (cycles, MEM_WAIT_EN with no wait states):
 - BEQ, BNE, J, JAL: 3
 - R-type, SW, ADDI, SLTI, LUI: 4
 - LW: 5
 Each cycle mem_ready_i is low in a memory state adds one cycle.

Reset
REQ-026 rst_ni low SHALL force state FETCH asynchronously and hold all write strobes (ir_write, pc_write, mem_write, reg_write) and illegal_op_o at 0 while rst_ni is low.
REQ-027 Reset mid-instruction SHALL abandon the instruction with no further writes; the first fetch SHALL begin on the first clock edge after release.

Structure
REQ-028 Package mips_pkg SHALL hold opcode/funct constants, the state enum, and the pc_src/alu_src/reg_dst/mem_to_reg/alu_op encodings.
REQ-029 Submodule mcp_out_dec SHALL map (state, op, funct, mem_ready) to outputs combinationally; the top module holds the state register and next-state logic.

Verification
REQ-030 LW, mem_ready=1 throughout -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 only in cycle 5, with mem_to_reg=01.
REQ-031 SW with mem_ready low for 2 cycles in MEMWR -> mem_write pulses exactly once, on the ready cycle; total 6 cycles.
REQ-032 BNE (op 000101) -> branch_ne=1, branch=0 in cycle 3. With EXT_OPS_EN=0 -> illegal_op_o pulses in DECODE and the FSM returns to FETCH.
REQ-033 R-type with funct 000010 -> apply_shift=1 in EXEC; with funct 100000 -> apply_shift=0.
REQ-034 JAL -> cycle 3 has pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-035 rst_ni asserted in MEMRD -> state_o4 reads FETCH immediately, all strobes 0, and no MEMWB write occurs.
